// File: rtl/ksa_share_arbiter.sv
// ksa_share_arbiter: shares one external combinational W-bit adder between two
// requesters. Round-robin (FAIR=1) or fixed-priority (FAIR=0) arbitration in IDLE,
// operands registered into the adder for one ISSUE cycle, result captured and held
// in RESP until the owning requester takes it.
// Optional feature macro: KSA_ARB_SUB_EN adds reqN_sub inputs; a request with
// sub=1 computes A - B (op_b = ~B, cin forced to 1, cout = no-borrow).
module ksa_share_arbiter #(
  parameter int W    = 64,
  parameter bit FAIR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
`ifdef KSA_ARB_SUB_EN
  input  logic         req0_sub,
`endif
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_sum,
  output logic         rsp0_cout,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
`ifdef KSA_ARB_SUB_EN
  input  logic         req1_sub,
`endif
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_sum,
  output logic         rsp1_cout,
  // shared adder
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_sum,
  input  logic         add_cout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_last;      // requester granted most recently (resets to 1 so req0 wins first tie)
  logic           r_owner;     // requester that owns the operation in flight
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic           r_op_cin;
  logic [W-1:0]   r_sum;
  logic           r_cout;

  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept;
  logic           w_rsp_take;
  logic [W-1:0]   w_sel_a;
  logic [W-1:0]   w_sel_b;
  logic           w_sel_cin;
  logic [W-1:0]   w_op_b_next;
  logic           w_op_cin_next;

  // Arbitration and next-state: grants only exist in IDLE, so ready is low while busy
  always_comb begin
    w_state_next = r_state;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_rsp_take   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid && req1_valid) begin
          if (FAIR && (r_last == 1'b0)) w_grant1 = 1'b1;
          else                          w_grant0 = 1'b1;
        end else if (req0_valid) begin
          w_grant0 = 1'b1;
        end else if (req1_valid) begin
          w_grant1 = 1'b1;
        end
        if (w_grant0 || w_grant1) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_state_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_take = (r_owner == 1'b0) ? rsp0_ready : rsp1_ready;
        if (w_rsp_take) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = w_grant0 | w_grant1;

  // Operand mux from the granted requester, with optional subtract conditioning
  always_comb begin
    w_sel_a       = w_grant1 ? req1_a   : req0_a;
    w_sel_b       = w_grant1 ? req1_b   : req0_b;
    w_sel_cin     = w_grant1 ? req1_cin : req0_cin;
`ifdef KSA_ARB_SUB_EN
    if (w_grant1 ? req1_sub : req0_sub) begin
      w_op_b_next   = ~w_sel_b;
      w_op_cin_next = 1'b1;
    end else begin
      w_op_b_next   = w_sel_b;
      w_op_cin_next = w_sel_cin;
    end
`else
    w_op_b_next   = w_sel_b;
    w_op_cin_next = w_sel_cin;
`endif
  end

  // State, arbitration pointer, operand and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cin <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_op_b_next;
        r_op_cin <= w_op_cin_next;
        r_owner  <= w_grant1;
        r_last   <= w_grant1;
      end
      if (r_state == S_ISSUE) begin
        r_sum  <= add_sum;
        r_cout <= add_cout;
      end
    end
  end

  // The adder only ever sees registered operands, so its inputs are glitch-free per cycle
  assign add_a   = r_op_a;
  assign add_b   = r_op_b;
  assign add_cin = r_op_cin;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  assign rsp0_valid = (r_state == S_RESP) && (r_owner == 1'b0);
  assign rsp1_valid = (r_state == S_RESP) && (r_owner == 1'b1);

  // One shared result register feeds both response ports
  assign rsp0_sum  = r_sum;
  assign rsp0_cout = r_cout;
  assign rsp1_sum  = r_sum;
  assign rsp1_cout = r_cout;

endmodule

// File: tb/tb_ksa_share_arbiter.sv
// Randomized bench for ksa_share_arbiter with a transaction-level reference model.
// Build with +define+KSA_ARB_SUB_EN to exercise the subtract option.
module tb_ksa_share_arbiter;
  localparam int W    = 64;
  localparam bit FAIR = 1'b1;
  localparam int NCYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req0_cin, rsp0_valid, rsp0_ready, rsp0_cout;
  logic [W-1:0] req0_a, req0_b, rsp0_sum;
  logic         req1_valid, req1_ready, req1_cin, rsp1_valid, rsp1_ready, rsp1_cout;
  logic [W-1:0] req1_a, req1_b, rsp1_sum;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         req0_sub, req1_sub;
  logic [W:0]   w_add_full;

  // External combinational adder
  assign w_add_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum    = w_add_full[W-1:0];
  assign add_cout   = w_add_full[W];

  ksa_share_arbiter #(.W(W), .FAIR(FAIR)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin),
`ifdef KSA_ARB_SUB_EN
    .req0_sub(req0_sub),
`endif
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin),
`ifdef KSA_ARB_SUB_EN
    .req1_sub(req1_sub),
`endif
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = '0;
      1:       v = '1;
      2:       v = W'($urandom_range(0, 15));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Reference model: one operation in flight, described by who owns it, how many
  // cycles have elapsed since acceptance, and the full (W+1)-bit arithmetic result.
  bit         m_busy;
  int         m_age;
  bit         m_owner;
  bit         m_last;
  bit         m_just_reset;
  logic [W-1:0] m_a, m_b;
  logic       m_cin;
  logic [W:0] m_res;
  logic [W:0] m_shown;

  initial begin
    int  g;
    bit  sub_sel;
    logic [W-1:0] b_eff;
    logic         cin_eff;
    rst = 1'b1;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0; req0_sub = 0; rsp0_ready = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0; req1_sub = 0; rsp1_ready = 0;
    m_busy = 0; m_age = 0; m_owner = 0; m_last = 1; m_just_reset = 0;
    m_a = '0; m_b = '0; m_cin = 0; m_res = '0; m_shown = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst        = (cyc < 2) || ($urandom_range(0, 59) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = rand_op(); req0_b = rand_op(); req0_cin = 1'($urandom_range(0, 1));
      req1_a = rand_op(); req1_b = rand_op(); req1_cin = 1'($urandom_range(0, 1));
`ifdef KSA_ARB_SUB_EN
      req0_sub = 1'($urandom_range(0, 1));
      req1_sub = 1'($urandom_range(0, 1));
`endif
      rsp0_ready = ($urandom_range(0, 2) == 0);
      rsp1_ready = ($urandom_range(0, 2) == 0);
      #1;

      // expected grant this cycle
      g = -1;
      if (!m_busy) begin
        if (req0_valid && req1_valid) g = (FAIR && !m_last) ? 1 : 0;
        else if (req0_valid)          g = 0;
        else if (req1_valid)          g = 1;
      end

      if (cyc > 1) begin
        check_val("req0_ready", (W+1)'(req0_ready), (W+1)'(g == 0));
        check_val("req1_ready", (W+1)'(req1_ready), (W+1)'(g == 1));
        check_val("rsp0_valid", (W+1)'(rsp0_valid), (W+1)'(m_busy && m_age >= 2 && m_owner == 0));
        check_val("rsp1_valid", (W+1)'(rsp1_valid), (W+1)'(m_busy && m_age >= 2 && m_owner == 1));
        check_val("rsp0_result", {rsp0_cout, rsp0_sum}, m_shown);
        check_val("rsp1_result", {rsp1_cout, rsp1_sum}, m_shown);
        if (m_busy && m_age == 1) begin
          check_val("issue_add_a", (W+1)'(add_a), (W+1)'(m_a));
          check_val("issue_add_b", (W+1)'(add_b), (W+1)'(m_b));
          check_val("issue_add_cin", (W+1)'(add_cin), (W+1)'(m_cin));
        end
        if (m_just_reset) begin
          check_val("reset_add_a", (W+1)'(add_a), '0);
          check_val("reset_add_b", (W+1)'(add_b), '0);
          check_val("reset_add_cin", (W+1)'(add_cin), '0);
        end
      end

      // model advances at the coming rising edge
      m_just_reset = rst;
      if (rst) begin
        m_busy = 0; m_age = 0; m_last = 1; m_shown = '0; m_a = '0; m_b = '0; m_cin = 0;
      end else if (!m_busy) begin
        if (g >= 0) begin
          sub_sel = 0;
`ifdef KSA_ARB_SUB_EN
          sub_sel = (g == 1) ? req1_sub : req0_sub;
`endif
          m_a     = (g == 1) ? req1_a : req0_a;
          b_eff   = (g == 1) ? req1_b : req0_b;
          cin_eff = (g == 1) ? req1_cin : req0_cin;
          if (sub_sel) begin
            b_eff   = ~b_eff;
            cin_eff = 1'b1;
          end
          m_b     = b_eff;
          m_cin   = cin_eff;
          m_res   = {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);
          m_owner = (g == 1);
          m_last  = (g == 1);
          m_busy  = 1;
          m_age   = 1;
          $display("ACCEPT cyc=%0d req%0d sub=%0d a=%h b=%h cin=%0d", cyc, g, sub_sel,
                   m_a, (g == 1) ? req1_b : req0_b, (g == 1) ? req1_cin : req0_cin);
        end
      end else if (m_age == 1) begin
        m_shown = m_res;
        m_age   = 2;
      end else if ((m_owner == 0) ? rsp0_ready : rsp1_ready) begin
        $display("RESP   cyc=%0d req%0d sum=%h cout=%0d", cyc, m_owner, m_res[W-1:0], m_res[W]);
        m_busy = 0;
      end else begin
        m_age++;
      end
      @(posedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
